// File: rtl/gb_timer.sv
// Game Boy style DIV/TIMA/TMA/TAC timer with a delayed TMA reload and an overflow interrupt.
// Latency: register writes take effect on the write edge; a timer-input falling edge bumps TIMA one clk later.
// Backpressure: none; register accesses are accepted every clk, counting advances only on ce.
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   ce              one-clk pulse per CPU T-cycle
//   addr/wr_en/wdata register select (0=DIV 1=TIMA 2=TMA 3=TAC), write strobe, write data
//   rdata           combinational read data for addr
//   timer_irq       one-clk overflow interrupt pulse
module gb_timer #(
    parameter int RELOAD_DELAY = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic [1:0] addr,
    input  logic       wr_en,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       timer_irq
);

    localparam int CW = (RELOAD_DELAY < 2) ? 1 : $clog2(RELOAD_DELAY);
    localparam logic [CW-1:0] LAST_TICK = CW'(RELOAD_DELAY - 1);

    typedef enum logic {
        IDLE,
        RELOAD_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     sys_cnt_q, sys_cnt_d;
    logic [7:0]      tima_q, tima_d;
    logic [7:0]      tma_q, tma_d;
    logic [2:0]      tac_q, tac_d;
    logic            t_in_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            irq_q, irq_d;

    logic wr_div, wr_tima, wr_tma, wr_tac;
    logic tap, t_in, t_fall, load_edge;

    assign wr_div  = wr_en && (addr == 2'd0);
    assign wr_tima = wr_en && (addr == 2'd1);
    assign wr_tma  = wr_en && (addr == 2'd2);
    assign wr_tac  = wr_en && (addr == 2'd3);

    // DIV write beats a same-edge increment.
    assign sys_cnt_d = wr_div ? 16'h0000 : (ce ? sys_cnt_q + 16'd1 : sys_cnt_q);
    assign tma_d     = wr_tma ? wdata : tma_q;
    assign tac_d     = wr_tac ? wdata[2:0] : tac_q;

    always_comb begin
        tap = 1'b0;
        case (tac_q[1:0])
            2'b00:   tap = sys_cnt_q[9];
            2'b01:   tap = sys_cnt_q[3];
            2'b10:   tap = sys_cnt_q[5];
            default: tap = sys_cnt_q[7];
        endcase
    end

    // Any falling edge counts, whether from the counter, a DIV clear or a TAC change.
    assign t_in   = tac_q[2] & tap;
    assign t_fall = t_in_q & ~t_in;

    assign load_edge = (state_q == RELOAD_WAIT) && ce && (cnt_q == LAST_TICK);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tima_d  = tima_q;
        irq_d   = 1'b0;

        if (state_q == RELOAD_WAIT && ce) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (t_fall) begin
            tima_d = tima_q + 8'd1;
            if (tima_q == 8'hFF) begin
                state_d = RELOAD_WAIT;
                cnt_d   = '0;
            end
        end

        // The reload edge owns TIMA: a TIMA write there is dropped, while a
        // same-edge TMA write is forwarded so the new value is loaded.
        if (load_edge) begin
            tima_d  = tma_d;
            irq_d   = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
        end else if (wr_tima) begin
            tima_d  = wdata;
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sys_cnt_q <= 16'h0000;
            tima_q    <= 8'h00;
            tma_q     <= 8'h00;
            tac_q     <= 3'b000;
            t_in_q    <= 1'b0;
            cnt_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sys_cnt_q <= sys_cnt_d;
            tima_q    <= tima_d;
            tma_q     <= tma_d;
            tac_q     <= tac_d;
            t_in_q    <= t_in;
            cnt_q     <= cnt_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (addr)
            2'd0:    rdata = sys_cnt_q[15:8];
            2'd1:    rdata = tima_q;
            2'd2:    rdata = tma_q;
            default: rdata = {5'b11111, tac_q};
        endcase
    end

    assign timer_irq = irq_q;

endmodule

// File: tb/tb_gb_timer.sv
module tb_gb_timer;

    logic       clk;
    logic       rst_n;
    logic       ce;
    logic [1:0] addr;
    logic       wr_en;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       timer_irq;

    int n_checks = 0;
    int n_fail   = 0;
    int irq_cnt  = 0;
    int irq_dbl  = 0;
    int exp_irq  = 0;
    logic irq_prev = 1'b0;

    gb_timer #(.RELOAD_DELAY(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .addr      (addr),
        .wr_en     (wr_en),
        .wdata     (wdata),
        .rdata     (rdata),
        .timer_irq (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count irq-high cycles and back-to-back irq cycles.
    always @(negedge clk) begin
        if (timer_irq) irq_cnt++;
        if (timer_irq && irq_prev) irq_dbl++;
        irq_prev = timer_irq;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        check(tag, {8'h00, rdata}, {8'h00, exp});
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One T-cycle: ce high for one clk, then an idle clk.
    task automatic tick(input int n);
        repeat (n) begin
            ce = 1'b1;
            @(posedge clk);
            #1;
            ce = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    // Final reload tick with a register write on the same edge.
    task automatic load_tick_wr(input logic [1:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        ce    = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        ce    = 1'b0;
        cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ce = 1'b0; wr_en = 1'b0; addr = 2'd0; wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_reg("rst_div", 2'd0, 8'h00);
        chk_reg("rst_tima", 2'd1, 8'h00);
        chk_reg("rst_tma", 2'd2, 8'h00);
        chk_reg("rst_tac", 2'd3, 8'hF8);
        check("rst_irq", {15'd0, timer_irq}, 16'd0);
        #3 rst_n = 1'b1;
        cyc(1);

        // Free-running DIV
        tick(512);
        chk_reg("div_512", 2'd0, 8'h02);
        chk_reg("tima_512", 2'd1, 8'h00);
        check("irq_512", 16'(irq_cnt), 16'(exp_irq));

        // Overflow and delayed reload
        wr(2'd1, 8'hFE);
        wr(2'd2, 8'h80);
        wr(2'd3, 8'h05);
        chk_reg("tac_rd", 2'd3, 8'hFD);
        wr(2'd0, 8'hA5);
        chk_reg("div_clr", 2'd0, 8'h00);
        tick(16);
        chk_reg("ovf_16", 2'd1, 8'hFF);
        tick(16);
        chk_reg("ovf_32", 2'd1, 8'h00);
        tick(3);
        chk_reg("wait_3", 2'd1, 8'h00);
        check("irq_wait", 16'(irq_cnt), 16'(exp_irq));
        tick(1);
        exp_irq++;
        chk_reg("reload", 2'd1, 8'h80);
        check("irq_reload", 16'(irq_cnt), 16'(exp_irq));

        // DIV write with the tap bit high causes one increment
        tick(4);
        wr(2'd0, 8'h00);
        chk_reg("divwr_same", 2'd1, 8'h80);
        cyc(1);
        chk_reg("divwr_inc", 2'd1, 8'h81);
        chk_reg("divwr_div", 2'd0, 8'h00);

        // TAC write with the tap bit high causes one increment
        tick(8);
        wr(2'd3, 8'h04);
        cyc(1);
        chk_reg("tacwr_inc", 2'd1, 8'h82);

        // TIMA write on the increment edge wins
        wr(2'd3, 8'h05);
        tick(7);
        ce = 1'b1;
        @(posedge clk);
        #1;
        ce = 1'b0;
        wr(2'd1, 8'h10);
        cyc(1);
        chk_reg("wr_beats_inc", 2'd1, 8'h10);

        // TIMA write inside the reload window cancels it
        wr(2'd1, 8'hFF);
        tick(16);
        chk_reg("cancel_ovf", 2'd1, 8'h00);
        tick(2);
        wr(2'd1, 8'h33);
        tick(6);
        chk_reg("cancel_tima", 2'd1, 8'h33);
        check("cancel_irq", 16'(irq_cnt), 16'(exp_irq));

        // TMA write on the load edge is loaded
        wr(2'd1, 8'hFF);
        tick(8);
        chk_reg("tmawr_ovf", 2'd1, 8'h00);
        tick(3);
        load_tick_wr(2'd2, 8'h55);
        exp_irq++;
        chk_reg("tmawr_tima", 2'd1, 8'h55);
        chk_reg("tmawr_tma", 2'd2, 8'h55);
        check("tmawr_irq", 16'(irq_cnt), 16'(exp_irq));

        // TIMA write on the load edge is ignored
        wr(2'd1, 8'hFF);
        tick(12);
        tick(3);
        load_tick_wr(2'd1, 8'h99);
        exp_irq++;
        chk_reg("timawr_load", 2'd1, 8'h55);
        check("timawr_irq", 16'(irq_cnt), 16'(exp_irq));

        // Increment inside the reload window, reload still happens
        tick(4);
        wr(2'd1, 8'hFF);
        wr(2'd3, 8'h04);
        cyc(1);
        chk_reg("win_ovf", 2'd1, 8'h00);
        wr(2'd3, 8'h05);
        tick(1);
        wr(2'd3, 8'h04);
        cyc(1);
        chk_reg("win_inc", 2'd1, 8'h01);
        tick(3);
        exp_irq++;
        chk_reg("win_reload", 2'd1, 8'h55);
        check("win_irq", 16'(irq_cnt), 16'(exp_irq));

        // Asynchronous reset inside the reload window
        wr(2'd3, 8'h05);
        wr(2'd1, 8'hFF);
        tick(4);
        chk_reg("ar_ovf", 2'd1, 8'h00);
        tick(2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        chk_reg("ar_tima", 2'd1, 8'h00);
        chk_reg("ar_tma", 2'd2, 8'h00);
        chk_reg("ar_tac", 2'd3, 8'hF8);
        chk_reg("ar_div", 2'd0, 8'h00);
        #2 rst_n = 1'b1;
        cyc(1);
        tick(6);
        chk_reg("ar_after", 2'd1, 8'h00);
        check("ar_irq", 16'(irq_cnt), 16'(exp_irq));
        check("irq_single", 16'(irq_dbl), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
